// File: rtl/dilithium_pkg.sv
// Shared constants, FSM encoding and the rejection test for the ExpandA
// sampler controller.
//  Q                    Dilithium modulus; a candidate is accepted iff t < Q
//  N_COEFF              coefficients per polynomial
//  SHAKE128_RATE_BYTES  SHAKE128 rate in bytes (56 three-byte candidates)
//  COEFF_W              coefficient width
package dilithium_pkg;

    localparam int unsigned Q                   = 32'd8380417;
    localparam int unsigned N_COEFF             = 32'd256;
    localparam int unsigned SHAKE128_RATE_BYTES = 32'd168;
    localparam int unsigned COEFF_W             = 32'd23;

    localparam int unsigned STATE_W  = 32'd1600;
    localparam int unsigned RATE_W   = SHAKE128_RATE_BYTES * 32'd8;
    localparam int unsigned OFF_W    = 32'd8;
    localparam int unsigned CNT_W    = 32'd9;
    localparam int unsigned IDX_W    = 32'd8;

    // Byte offset of the last three-byte candidate inside the rate (165).
    localparam logic [OFF_W-1:0] LAST_OFF   = 8'd165;
    localparam logic [CNT_W-1:0] LAST_CNT   = 9'd255;
    localparam logic [COEFF_W-1:0] Q_VAL    = 23'd8380417;

    localparam logic [2:0] ST_IDLE_ENC = 3'd0;
    localparam logic [2:0] ST_FIRE_ENC = 3'd1;
    localparam logic [2:0] ST_WAIT_ENC = 3'd2;
    localparam logic [2:0] ST_LOAD_ENC = 3'd3;
    localparam logic [2:0] ST_SCAN_ENC = 3'd4;
    localparam logic [2:0] ST_DONE_ENC = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_FIRE = ST_FIRE_ENC,
        ST_WAIT = ST_WAIT_ENC,
        ST_LOAD = ST_LOAD_ENC,
        ST_SCAN = ST_SCAN_ENC,
        ST_DONE = ST_DONE_ENC
    } state_t;

    // Rejection-sampling acceptance test on a 23-bit candidate.
    function automatic logic coeff_accept(input logic [COEFF_W-1:0] t);
        return (t < Q_VAL);
    endfunction

endpackage

// File: rtl/rej_candidate_sel.sv
// Combinational candidate extractor for rejection sampling.
//  blk     in   rate portion of the latched Keccak state (byte k = blk[8k+7:8k])
//  off     in   byte offset of the candidate (0, 3, ..., 165)
//  t       out  23-bit candidate {byte off+2 [6:0], byte off+1, byte off}
//  accept  out  1 when t < Q
module rej_candidate_sel
    import dilithium_pkg::*;
(
    input  logic [RATE_W-1:0]  blk,
    input  logic [OFF_W-1:0]   off,
    output logic [COEFF_W-1:0] t,
    output logic               accept
);

    logic [10:0] bit_base_s;

    // Taking only 23 bits from the byte boundary drops bit 7 of the third byte.
    assign bit_base_s = {off, 3'b000};
    assign t          = blk[bit_base_s +: COEFF_W];
    assign accept     = coeff_accept(t);

endmodule

// File: rtl/expand_a_sampler_ctrl.sv
// ExpandA sampler controller: drives the SHAKE128 G-function datapath to
// generate one polynomial A[i][j] by rejection sampling and streams the 256
// accepted coefficients out over a valid/ready port.
//  clk, rst            clock, asynchronous active-high reset
//  req                 start one polynomial (sampled only in IDLE)
//  rho, i, j           seed and matrix coordinates, captured on accepted req
//  busy, done          busy from accepted req until done; done is a 1-cycle pulse
//  g_start, g_rho_en   start pulse to G; rho_en=1 only for the first permutation
//  g_rho, g_i, g_j     registered seed and coordinates
//  g_keccak_in         state from the previous permutation, fed back for squeezing
//  g_keccak_out,g_done permutation result and its completion pulse
//  coeff_valid/ready   coefficient handshake
//  coeff_data/idx      coefficient value and its index 0..255
module expand_a_sampler_ctrl
    import dilithium_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic [255:0]       rho,
    input  logic [7:0]         i,
    input  logic [7:0]         j,
    output logic               busy,
    output logic               done,
    output logic               g_start,
    output logic               g_rho_en,
    output logic [255:0]       g_rho,
    output logic [7:0]         g_i,
    output logic [7:0]         g_j,
    output logic [STATE_W-1:0] g_keccak_in,
    input  logic [STATE_W-1:0] g_keccak_out,
    input  logic               g_done,
    output logic               coeff_valid,
    input  logic               coeff_ready,
    output logic [COEFF_W-1:0] coeff_data,
    output logic [IDX_W-1:0]   coeff_idx
);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [OFF_W-1:0]   off_r;
    logic [OFF_W-1:0]   off_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic               hs_s;
    logic               adv_s;
    logic [COEFF_W-1:0] cand_t_s;
    logic               cand_acc_s;

    // The candidate is evaluated at the offset the scan will hold next cycle,
    // so coeff_valid/coeff_data can be registered and still appear in the
    // same cycle as their offset. g_keccak_in doubles as the sampled block.
    rej_candidate_sel u_sel (
        .blk    (g_keccak_in[RATE_W-1:0]),
        .off    (off_nxt_s),
        .t      (cand_t_s),
        .accept (cand_acc_s)
    );

    // Next-state, scan offset and coefficient counter.
    always_comb begin
        state_nxt_s = state_r;
        off_nxt_s   = off_r;
        cnt_nxt_s   = cnt_r;
        hs_s        = 1'b0;
        adv_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    state_nxt_s = ST_FIRE;
                    off_nxt_s   = 8'd0;
                    cnt_nxt_s   = 9'd0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FIRE: begin
                state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (g_done) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_LOAD: begin
                state_nxt_s = ST_SCAN;
                off_nxt_s   = 8'd0;
            end
            ST_SCAN: begin
                hs_s  = coeff_valid && coeff_ready;
                adv_s = !coeff_valid || coeff_ready;
                if (hs_s) begin
                    cnt_nxt_s = cnt_r + 9'd1;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
                // The 256th handshake wins over a simultaneous block end.
                if (hs_s && (cnt_r == LAST_CNT)) begin
                    state_nxt_s = ST_DONE;
                end else if (adv_s && (off_r == LAST_OFF)) begin
                    state_nxt_s = ST_FIRE;
                    off_nxt_s   = 8'd0;
                end else if (adv_s) begin
                    state_nxt_s = ST_SCAN;
                    off_nxt_s   = off_r + 8'd3;
                end else begin
                    state_nxt_s = ST_SCAN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            off_r       <= 8'd0;
            cnt_r       <= 9'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            g_start     <= 1'b0;
            g_rho_en    <= 1'b0;
            g_rho       <= 256'd0;
            g_i         <= 8'd0;
            g_j         <= 8'd0;
            g_keccak_in <= {STATE_W{1'b0}};
            coeff_valid <= 1'b0;
            coeff_data  <= 23'd0;
            coeff_idx   <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            off_r   <= off_nxt_s;
            cnt_r   <= cnt_nxt_s;
            busy    <= (state_nxt_s != ST_IDLE);
            done    <= (state_nxt_s == ST_DONE);
            g_start <= (state_nxt_s == ST_FIRE);

            if ((state_r == ST_IDLE) && (state_nxt_s == ST_FIRE)) begin
                g_rho    <= rho;
                g_i      <= i;
                g_j      <= j;
                g_rho_en <= 1'b1;
            end else if (state_nxt_s == ST_LOAD) begin
                g_rho_en <= 1'b0;
            end else begin
                g_rho_en <= g_rho_en;
            end

            if ((state_r == ST_WAIT) && g_done) begin
                g_keccak_in <= g_keccak_out;
            end else begin
                g_keccak_in <= g_keccak_in;
            end

            coeff_valid <= (state_nxt_s == ST_SCAN) && cand_acc_s;
            if (state_nxt_s == ST_SCAN) begin
                coeff_data <= cand_t_s;
                coeff_idx  <= cnt_nxt_s[IDX_W-1:0];
            end else begin
                coeff_data <= coeff_data;
                coeff_idx  <= coeff_idx;
            end
        end
    end

endmodule
